gb_lcd_stream: RTL and testbench
================================

GB_LCD_STREAM -- requirements
Module: gb_lcd_stream

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 160: active pixel slots per line.
REQ-002 SHALL have parameter H_TOTAL, default 228: pixel slots per line, blanking included.
REQ-003 SHALL have parameter V_ACTIVE, default 144: active lines per frame.
REQ-004 SHALL have parameter V_TOTAL, default 154: lines per frame.
REQ-005 SHALL have parameter HS_START, default 164: first slot of a line with gb_hsync high.
REQ-006 SHALL have parameter HS_LEN, default 8: gb_hsync width in slots.
REQ-007 SHALL have parameter VS_LINES, default 2: gb_vsync width in lines, starting at line V_ACTIVE.
REQ-008 SHALL have port pclk, input, 1: the single clock; all logic is on its rising edge.
REQ-009 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-010 SHALL have port en, input, 1: run request, sampled only in IDLE and at end of frame.
REQ-011 SHALL have port fb_addr, output, 15: frame-RAM read address.
REQ-012 SHALL have port fb_rd, output, 1: read strobe.
REQ-013 SHALL have port fb_data, input, 2: RAM data, valid on the edge after fb_rd.
REQ-014 SHALL have the outputs gb_pclk, gb_de, gb_hsync, gb_vsync (1 bit each) and gb_pixel (2 bits): the GB LCD stream.
REQ-015 SHALL have port frame_done, output, 1: one-pclk pulse at the end of each frame.

Function
REQ-016 SHALL implement the FSM states IDLE and RUN.
- IDLE -> RUN when en=1; the slot counter h and the line counter v start at 0.
- RUN -> IDLE at the end of the last slot of line V_TOTAL-1 when en=0.
- RUN wraps to h=0, v=0 at that point when en=1.
REQ-017 SHALL, in RUN, toggle gb_pclk on every pclk edge, so gb_pclk = pclk/2; in IDLE, gb_pclk SHALL be held at 0.
- One slot is two pclk cycles.
- Every stream output changes only on the edge where gb_pclk goes 1->0, so the receiver can sample on the rising edge of gb_pclk.
REQ-018 SHALL advance h by 1 per slot, wrapping at H_TOTAL-1; v SHALL increment on each h wrap and wrap at V_TOTAL-1.
REQ-019 SHALL drive gb_de=1 exactly for slots with h<H_ACTIVE and v<V_ACTIVE.
REQ-020 SHALL drive gb_hsync=1 for HS_START<=h<HS_START+HS_LEN on every line.
REQ-021 SHALL drive gb_vsync=1 for all slots with V_ACTIVE<=v<V_ACTIVE+VS_LINES.
REQ-022 SHALL, on the gb_pclk 0->1 edge that precedes an active slot, assert fb_rd for one pclk with fb_addr = v*H_ACTIVE+h for that slot.
- The multiply is computed at full width and truncated to 15 bits.
- fb_rd SHALL never be asserted for blanking slots.
REQ-023 SHALL register fb_data into gb_pixel on the following 1->0 edge; gb_pixel SHALL be 0 whenever gb_de=0.
REQ-024 SHALL assert frame_done for one pclk on the last pclk of slot (H_TOTAL-1, V_TOTAL-1), including the final frame before IDLE.
REQ-025 SHALL NOT abort a frame when en drops mid-frame; the frame completes in full.
REQ-026 SHALL produce a frame period of H_TOTAL*V_TOTAL*2 pclk cycles, which is 70224 at the default parameters.

Reset
REQ-027 SHALL, with rst=1 at a rising edge of pclk, force the following on the next state: state=IDLE, h=0, v=0, and 0 on gb_pclk, gb_de, gb_hsync, gb_vsync, gb_pixel, fb_rd, fb_addr and frame_done.
REQ-028 SHALL treat rst mid-frame as an immediate abort with no frame_done; the next frame after reset starts at h=0, v=0.

Configuration
REQ-029 SHALL, when the macro GB_LCD_TEST_PATTERN_EN is defined, add input port test_mode (1 bit).
- While test_mode=1: gb_pixel = h[4:3] ^ v[4:3] for active slots, fb_rd stays 0, and timing is unchanged.
- Without the macro: no test_mode port, and pixels always come from fb_data.

Verification
REQ-030 SHALL check default parameters with en=1 and fb_data=addr[1:0]: first frame_done 70224 pclk after RUN entry; 23040 gb_de-high slots per frame; first slot gb_pixel=0, second gb_pixel=1.
REQ-031 SHALL check line timing: gb_hsync high for 8 slots starting at h=164 on every line; gb_de falls after slot 159; the gb_pixel for v=1,h=0 uses fb_addr=160.
REQ-032 SHALL check frame timing: gb_vsync high for exactly 2*228 slots starting at v=144; last active fb_addr=23039; no fb_rd in lines 144-153.
REQ-033 SHALL check en dropped at v=10: frame runs to v=153, frame_done pulses once, then IDLE with gb_pclk held 0 and all stream outputs 0.
REQ-034 SHALL check rst asserted at v=50,h=80: on the next edge all outputs are 0 with no frame_done; after release with en=1, the first fb_addr=0.
REQ-035 SHALL check, with GB_LCD_TEST_PATTERN_EN defined and test_mode=1: gb_pixel=2'b01 at h=8,v=0; gb_pixel=2'b00 at h=8,v=8; fb_rd never asserted.

Source files
------------

// File: rtl/gb_lcd_stream.sv
// rtl/gb_lcd_stream.sv - Game Boy LCD pixel stream generator reading a 2-bit frame RAM
// Optional GB_LCD_TEST_PATTERN_EN adds test_mode, which replaces RAM pixels with a checker pattern.
module gb_lcd_stream #(
  parameter int H_ACTIVE = 160,
  parameter int H_TOTAL  = 228,
  parameter int V_ACTIVE = 144,
  parameter int V_TOTAL  = 154,
  parameter int HS_START = 164,
  parameter int HS_LEN   = 8,
  parameter int VS_LINES = 2
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        en,
`ifdef GB_LCD_TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic [14:0] fb_addr,
  output logic        fb_rd,
  input  logic [1:0]  fb_data,
  output logic        gb_pclk,
  output logic        gb_de,
  output logic        gb_hsync,
  output logic        gb_vsync,
  output logic [1:0]  gb_pixel,
  output logic        frame_done
);

  localparam logic [15:0] HA  = 16'(H_ACTIVE);
  localparam logic [15:0] HT  = 16'(H_TOTAL);
  localparam logic [15:0] VA  = 16'(V_ACTIVE);
  localparam logic [15:0] VT  = 16'(V_TOTAL);
  localparam logic [15:0] HSS = 16'(HS_START);
  localparam logic [15:0] HSE = 16'(HS_START + HS_LEN);
  localparam logic [15:0] VSE = 16'(V_ACTIVE + VS_LINES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [15:0] h_q, h_d, v_q, v_d;
  logic        gb_pclk_q, gb_pclk_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [1:0]  pix_q, pix_d;
  logic        fb_rd_q, fb_rd_d;
  logic [14:0] fb_addr_q, fb_addr_d;
  logic        frame_done_q, frame_done_d;

  logic        tp;
  logic        active;
  logic [14:0] addr;
  logic [1:0]  pattern;

  // h/v name the slot being fetched on the rising gb_pclk edge and shown on the next falling one.
  always_comb begin
`ifdef GB_LCD_TEST_PATTERN_EN
    tp = test_mode;
`else
    tp = 1'b0;
`endif
    active  = (h_q < HA) && (v_q < VA);
    addr    = v_q[14:0] * HA[14:0] + h_q[14:0];
    pattern = h_q[4:3] ^ v_q[4:3];

    state_d      = state_q;
    h_d          = h_q;
    v_d          = v_q;
    gb_pclk_d    = gb_pclk_q;
    de_d         = de_q;
    hs_d         = hs_q;
    vs_d         = vs_q;
    pix_d        = pix_q;
    fb_rd_d      = 1'b0;
    fb_addr_d    = fb_addr_q;
    frame_done_d = 1'b0;

    case (state_q)
      IDLE: begin
        gb_pclk_d = 1'b0;
        de_d      = 1'b0;
        hs_d      = 1'b0;
        vs_d      = 1'b0;
        pix_d     = 2'b00;
        h_d       = 16'd0;
        v_d       = 16'd0;
        if (en) state_d = RUN;
      end
      default: begin
        gb_pclk_d = ~gb_pclk_q;
        if (!gb_pclk_q) begin
          fb_rd_d = active && !tp;
          if (active && !tp) fb_addr_d = addr;
        end else begin
          de_d  = active;
          hs_d  = (h_q >= HSS) && (h_q < HSE);
          vs_d  = (v_q >= VA) && (v_q < VSE);
          pix_d = !active ? 2'b00 : (tp ? pattern : fb_data);
          if (h_q == HT - 16'd1) begin
            h_d = 16'd0;
            if (v_q == VT - 16'd1) begin
              v_d          = 16'd0;
              frame_done_d = 1'b1;
              if (!en) begin
                state_d = IDLE;
                de_d    = 1'b0;
                hs_d    = 1'b0;
                vs_d    = 1'b0;
                pix_d   = 2'b00;
              end
            end else begin
              v_d = v_q + 16'd1;
            end
          end else begin
            h_d = h_q + 16'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q      <= IDLE;
      h_q          <= 16'd0;
      v_q          <= 16'd0;
      gb_pclk_q    <= 1'b0;
      de_q         <= 1'b0;
      hs_q         <= 1'b0;
      vs_q         <= 1'b0;
      pix_q        <= 2'b00;
      fb_rd_q      <= 1'b0;
      fb_addr_q    <= 15'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      gb_pclk_q    <= gb_pclk_d;
      de_q         <= de_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      pix_q        <= pix_d;
      fb_rd_q      <= fb_rd_d;
      fb_addr_q    <= fb_addr_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fb_addr    = fb_addr_q;
  assign fb_rd      = fb_rd_q;
  assign gb_pclk    = gb_pclk_q;
  assign gb_de      = de_q;
  assign gb_hsync   = hs_q;
  assign gb_vsync   = vs_q;
  assign gb_pixel   = pix_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_gb_lcd_stream.sv
// tb/tb_gb_lcd_stream.sv - directed bench for gb_lcd_stream at default parameters
module tb_gb_lcd_stream;

  localparam int N_SLOTS   = 228 * 154;
  localparam int FRAME_CYC = 2 * N_SLOTS;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic rst, en, rst2, en2;
  logic started = 1'b0;
  int   n = -1;

  logic [14:0] fb_addr_a, fb_addr_b;
  logic        fb_rd_a, fb_rd_b;
  logic [1:0]  fb_data_a, fb_data_b;
  logic        gb_pclk_a, gb_de_a, gb_hsync_a, gb_vsync_a, frame_done_a;
  logic        gb_pclk_b, gb_de_b, gb_hsync_b, gb_vsync_b, frame_done_b;
  logic [1:0]  gb_pixel_a, gb_pixel_b;

  assign fb_data_a = fb_addr_a[1:0];
  assign fb_data_b = fb_addr_b[1:0];

  gb_lcd_stream dut_a (
    .pclk(pclk), .rst(rst), .en(en),
`ifdef GB_LCD_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .fb_addr(fb_addr_a), .fb_rd(fb_rd_a), .fb_data(fb_data_a),
    .gb_pclk(gb_pclk_a), .gb_de(gb_de_a), .gb_hsync(gb_hsync_a), .gb_vsync(gb_vsync_a),
    .gb_pixel(gb_pixel_a), .frame_done(frame_done_a)
  );

  gb_lcd_stream dut_b (
    .pclk(pclk), .rst(rst2), .en(en2),
`ifdef GB_LCD_TEST_PATTERN_EN
    .test_mode(1'b0),
`endif
    .fb_addr(fb_addr_b), .fb_rd(fb_rd_b), .fb_data(fb_data_b),
    .gb_pclk(gb_pclk_b), .gb_de(gb_de_b), .gb_hsync(gb_hsync_b), .gb_vsync(gb_vsync_b),
    .gb_pixel(gb_pixel_b), .frame_done(frame_done_b)
  );

`ifdef GB_LCD_TEST_PATTERN_EN
  logic [14:0] fb_addr_c;
  logic        fb_rd_c, gb_pclk_c, gb_de_c, gb_hsync_c, gb_vsync_c, frame_done_c;
  logic [1:0]  gb_pixel_c, fb_data_c;
  logic [1:0]  pix_c_08, pix_c_88;
  int          rd_c_cnt = 0;
  assign fb_data_c = fb_addr_c[1:0];

  gb_lcd_stream dut_c (
    .pclk(pclk), .rst(rst), .en(en), .test_mode(1'b1),
    .fb_addr(fb_addr_c), .fb_rd(fb_rd_c), .fb_data(fb_data_c),
    .gb_pclk(gb_pclk_c), .gb_de(gb_de_c), .gb_hsync(gb_hsync_c), .gb_vsync(gb_vsync_c),
    .gb_pixel(gb_pixel_c), .frame_done(frame_done_c)
  );

  always @(negedge pclk) begin
    if (n >= 1 && n <= FRAME_CYC) begin
      if (fb_rd_c) rd_c_cnt++;
      if (n == 2 * (8 + 1)) pix_c_08 = gb_pixel_c;
      if (n == 2 * (8 * 228 + 8 + 1)) pix_c_88 = gb_pixel_c;
    end
  end
`endif

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  always @(posedge pclk) if (started) n <= n + 1;

  int pclk_err = 0, rd_err = 0, addr_err = 0, de_err = 0, hs_err = 0, vs_err = 0, pix_err = 0;
  int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, rd_cnt = 0, rd_blank = 0, idle_err = 0;
  int fd_cnt = 0, fd_n = -1, fd_b_cnt = 0;
  logic [14:0] last_addr = '0, addr_v1h0 = '0;
  logic [1:0]  pix_first = '1, pix_second = '0, pix_v1h0 = '1;
  logic        de_159 = 1'b0, de_160 = 1'b1;

  always @(negedge pclk) begin : mon
    int d, s, h, v;
    bit act;
    logic [1:0] ep;
    if (n >= 0) begin
      if (frame_done_a) begin
        fd_cnt++;
        if (fd_n < 0) fd_n = n;
      end
      if (frame_done_b) fd_b_cnt++;
    end
    if (n >= 1 && n <= FRAME_CYC) begin
      if (gb_pclk_a !== (n % 2 == 1)) pclk_err++;
      if (n % 2 == 1) begin
        s = (n - 1) / 2; h = s % 228; v = s / 228;
        act = (h < 160) && (v < 144);
        if (fb_rd_a !== act) rd_err++;
        if (act && fb_addr_a != 15'(v * 160 + h)) addr_err++;
        if (fb_rd_a) begin
          rd_cnt++;
          last_addr = fb_addr_a;
          if (v >= 144) rd_blank++;
        end
        if (s == 228) addr_v1h0 = fb_addr_a;
      end else if (fb_rd_a !== 1'b0) begin
        rd_err++;
      end
      d = n / 2 - 1;
      if (d >= 0) begin
        h = d % 228; v = d / 228;
        act = (h < 160) && (v < 144);
        ep = act ? 2'((v * 160 + h) % 4) : 2'd0;
        if (gb_de_a !== act) de_err++;
        if (gb_hsync_a !== (h >= 164 && h < 172)) hs_err++;
        if (gb_vsync_a !== (v >= 144 && v < 146)) vs_err++;
        if (gb_pixel_a !== ep) pix_err++;
        if (n % 2 == 0) begin
          de_cnt += int'(gb_de_a);
          hs_cnt += int'(gb_hsync_a);
          vs_cnt += int'(gb_vsync_a);
          if (d == 0) pix_first = gb_pixel_a;
          if (d == 1) pix_second = gb_pixel_a;
          if (d == 159) de_159 = gb_de_a;
          if (d == 160) de_160 = gb_de_a;
          if (d == 228) pix_v1h0 = gb_pixel_a;
        end
      end
    end
    if (n > FRAME_CYC && n <= FRAME_CYC + 20) begin
      if ({gb_pclk_a, gb_de_a, gb_hsync_a, gb_vsync_a, gb_pixel_a, fb_rd_a} != 7'd0) idle_err++;
    end
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; en = 1'b0; en2 = 1'b0;
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    check("reset_outputs_a", {gb_pclk_a, gb_de_a, gb_hsync_a, gb_vsync_a, gb_pixel_a, fb_rd_a, fb_addr_a, frame_done_a}, 0);
    check("reset_outputs_b", {gb_pclk_b, gb_de_b, gb_hsync_b, gb_vsync_b, gb_pixel_b, fb_rd_b, fb_addr_b, frame_done_b}, 0);
    rst = 1'b0; rst2 = 1'b0;
    @(negedge pclk);
    check("idle_no_en_pclk", gb_pclk_a, 0);
    check("idle_no_en_rd", fb_rd_a, 0);
    en = 1'b1; en2 = 1'b1; started = 1'b1;

    while (n < 2 * (10 * 228) + 1) @(negedge pclk);
    en = 1'b0;

    while (n < 22959) @(negedge pclk);
    check("b_pre_rst_addr", fb_addr_b, 50 * 160 + 79);
    check("b_pre_rst_de", gb_de_b, 1);
    @(negedge pclk);
    rst2 = 1'b1;
    @(negedge pclk);
    check("b_rst_outputs", {gb_pclk_b, gb_de_b, gb_hsync_b, gb_vsync_b, gb_pixel_b, fb_rd_b, fb_addr_b, frame_done_b}, 0);
    rst2 = 1'b0;
    @(negedge pclk);
    check("b_run_entry_rd", fb_rd_b, 0);
    @(negedge pclk);
    check("b_first_rd", fb_rd_b, 1);
    check("b_first_addr", fb_addr_b, 0);
    @(negedge pclk);
    @(negedge pclk);
    check("b_second_addr", fb_addr_b, 1);

    while (n < FRAME_CYC + 25) @(negedge pclk);

    check("frame_done_latency", fd_n, FRAME_CYC);
    check("frame_done_pulses", fd_cnt, 1);
    check("de_slot_count", de_cnt, 23040);
    check("pixel_first", pix_first, 0);
    check("pixel_second", pix_second, 1);
    check("addr_v1_h0", addr_v1h0, 160);
    check("pixel_v1_h0", pix_v1h0, 0);
    check("de_at_h159", de_159, 1);
    check("de_at_h160", de_160, 0);
    check("hsync_slot_count", hs_cnt, 8 * 154);
    check("hsync_pattern_err", hs_err, 0);
    check("vsync_slot_count", vs_cnt, 2 * 228);
    check("vsync_pattern_err", vs_err, 0);
    check("de_pattern_err", de_err, 0);
    check("pixel_err", pix_err, 0);
    check("last_active_addr", last_addr, 23039);
    check("rd_in_blank_lines", rd_blank, 0);
    check("rd_count", rd_cnt, 23040);
    check("rd_timing_err", rd_err, 0);
    check("addr_err", addr_err, 0);
    check("gb_pclk_err", pclk_err, 0);
    check("idle_after_frame_err", idle_err, 0);
    check("b_frame_done_after_rst", fd_b_cnt, 0);
`ifdef GB_LCD_TEST_PATTERN_EN
    check("tp_pixel_h8_v0", pix_c_08, 2'b01);
    check("tp_pixel_h8_v8", pix_c_88, 2'b00);
    check("tp_rd_count", rd_c_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
